load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   OPCODE_WIDTH / FUNCT3_WIDTH  field widths of the instruction opcode and funct3
//   OPCODE_LOAD / OPCODE_STORE   RV32I major opcodes for loads and stores
//   FUNCT3_*                     width/sign selectors for each access type
//   lsu_state_e                  FSM state encoding (IDLE, ACCESS, RESP)
//   isLegal()                    true when an opcode/funct3 pair is a supported access
package load_store_unit_pkg;

  localparam int OPCODE_WIDTH = 7;
  localparam int FUNCT3_WIDTH = 3;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 7'b0100011;

  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LW  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LBU = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LHU = 3'b101;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Stores have no unsigned variants, so only loads accept funct3 = 100/101.
  function automatic logic isLegal(input logic [OPCODE_WIDTH-1:0] opcode,
                                   input logic [FUNCT3_WIDTH-1:0] funct3);
    case (opcode)
      OPCODE_LOAD:  isLegal = funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW,
                                             FUNCT3_LBU, FUNCT3_LHU};
      OPCODE_STORE: isLegal = funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
      default:      isLegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   i_size        access size, funct3[1:0] (00 byte, 01 half, 10 word)
//   i_off         byte offset inside the word, addr[1:0]
//   i_wdata       right-justified store data
//   i_rdata       raw little-endian load word from memory
//   o_be          byte enables for a store of this size/offset
//   o_wdata       store data replicated across every lane
//   o_rdata       load data with the addressed field moved to the top, rest zero
//   o_misaligned  size/offset combination cannot be done in one access
// Sign extension is left to the downstream decoder, so funct3[2] is not needed.
module lsu_lane_align (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  // Replicating store data means whichever lanes o_be selects already hold
  // the right bytes, so no barrel shifter is needed on the write side.
  // Load data keeps only the addressed byte/halfword, parked at the top.
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_rdata      = 32'h0;
    o_misaligned = 1'b0;
    case (i_size)
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        case (i_off)
          2'd0:    o_rdata = {i_rdata[7:0],   24'h0};
          2'd1:    o_rdata = {i_rdata[15:8],  24'h0};
          2'd2:    o_rdata = {i_rdata[23:16], 24'h0};
          default: o_rdata = {i_rdata[31:24], 24'h0};
        endcase
      end
      2'b01: begin
        o_be         = 4'b0011 << i_off;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_off[0];
        o_rdata      = i_off[1] ? {i_rdata[31:16], 16'h0} : {i_rdata[15:0], 16'h0};
      end
      2'b10: begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = |i_off;
        o_rdata      = i_rdata;
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end between execute and data memory.
// Ports:
//   clk, rst_n                     clock and synchronous active-low reset
//   req_valid/req_ready            one request at a time from execute
//   req_opcode/funct3/addr/wdata   request fields, latched on accept
//   mem_req/we/be/addr/wdata       word-wide req/ack bus, held until mem_ack
//   mem_ack/mem_rdata              completion and load word from memory
//   resp_valid/resp_ready          response handshake to the data-memory decoder
//   resp_data/opcode/funct3/err    lane-aligned load data, echoed fields, error
// Errors (illegal op, misaligned, timeout) return resp_err=1 with zero data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] req_opcode,
  input  logic [FUNCT3_WIDTH-1:0] req_funct3,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [N-1:0]            req_wdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [N-1:0]            mem_wdata,
  input  logic                    mem_ack,
  input  logic [N-1:0]            mem_rdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [N-1:0]            resp_data,
  output logic [OPCODE_WIDTH-1:0] resp_opcode,
  output logic [FUNCT3_WIDTH-1:0] resp_funct3,
  output logic                    resp_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e              r_state;
  lsu_state_e              w_nextState;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [FUNCT3_WIDTH-1:0] r_funct3;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_memWe;
  logic [3:0]              r_memBe;
  logic [N-1:0]            r_memWdata;
  logic [N-1:0]            r_respData;
  logic                    r_respErr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_isStore;
  logic                    w_good;
  logic [1:0]              w_alSize;
  logic [1:0]              w_alOff;
  logic [3:0]              w_alBe;
  logic [31:0]             w_alWdata;
  logic [31:0]             w_alRdata;
  logic                    w_misaligned;

  // In IDLE the aligner looks at the incoming request to build the store
  // lanes and misalignment flag; afterwards it looks at the latched request
  // so the load word returned on ack is steered by the original offset.
  assign w_alSize = (r_state == ST_IDLE) ? req_funct3[1:0] : r_funct3[1:0];
  assign w_alOff  = (r_state == ST_IDLE) ? req_addr[1:0]   : r_addr[1:0];

  lsu_lane_align u_align (
    .i_size       (w_alSize),
    .i_off        (w_alOff),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_be         (w_alBe),
    .o_wdata      (w_alWdata),
    .o_rdata      (w_alRdata),
    .o_misaligned (w_misaligned)
  );

  assign w_isStore = (req_opcode == OPCODE_STORE);
  assign w_good    = isLegal(req_opcode, req_funct3) && !w_misaligned;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Bad requests skip the bus entirely; in ACCESS an ack
  // takes priority over the timeout so an ack in the last cycle still counts.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_nextState = w_good ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || (r_count == CNT_LAST)) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Request latch, bus fields, timeout counter and response registers.
  // Everything the outside world sees is held here so that nothing on the
  // response side depends combinationally on mem_ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_memWe    <= 1'b0;
      r_memBe    <= 4'b0000;
      r_memWdata <= '0;
      r_respData <= '0;
      r_respErr  <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_opcode   <= req_opcode;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_memWe    <= w_isStore && w_good;
            r_memBe    <= (w_isStore && w_good) ? w_alBe : 4'b0000;
            r_memWdata <= (w_isStore && w_good) ? w_alWdata : '0;
            r_respData <= '0;
            r_respErr  <= !w_good;
            r_count    <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_respData <= r_memWe ? '0 : w_alRdata;
            r_respErr  <= 1'b0;
          end else if (r_count == CNT_LAST) begin
            r_respErr  <= 1'b1;
          end else begin
            r_count    <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign mem_req     = (r_state == ST_ACCESS);
  assign resp_valid  = (r_state == ST_RESP);
  assign mem_we      = r_memWe;
  assign mem_be      = r_memBe;
  assign mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata   = r_memWdata;
  assign resp_data   = r_respData;
  assign resp_opcode = r_opcode;
  assign resp_funct3 = r_funct3;
  assign resp_err    = r_respErr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT set to 4).
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [6:0]  resp_opcode;
  logic [2:0]  resp_funct3;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.N(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_opcode (resp_opcode),
    .resp_funct3 (resp_funct3),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load vectors: funct3, address, memory word, expected aligned data.
  logic [2:0]  ldF3   [6] = '{3'b000, 3'b001, 3'b001, 3'b100, 3'b010, 3'b000};
  logic [31:0] ldAddr [6] = '{32'h101, 32'h102, 32'h100, 32'h003, 32'h010, 32'h102};
  logic [31:0] ldRd   [6] = '{32'hAABBCCDD, 32'h80011234, 32'h80011234,
                              32'h11223344, 32'hDEADBEEF, 32'hAABBCCDD};
  logic [31:0] ldExp  [6] = '{32'hCC000000, 32'h80010000, 32'h12340000,
                              32'h11000000, 32'hDEADBEEF, 32'hBB000000};

  // Store vectors: funct3, address, data, expected byte enables and bus data.
  logic [2:0]  stF3   [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
  logic [31:0] stAddr [4] = '{32'h203, 32'h302, 32'h400, 32'h200};
  logic [31:0] stWd   [4] = '{32'h000000A5, 32'h1234BEEF, 32'h12345678, 32'hFFFFFF77};
  logic [3:0]  stBe   [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0001};
  logic [31:0] stExp  [4] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678, 32'h77777777};

  // Bad requests: opcode, funct3, address. All must error without bus activity.
  logic [6:0]  bdOp   [4] = '{7'b0000011, 7'b0000011, 7'b0110011, 7'b0100011};
  logic [2:0]  bdF3   [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
  logic [31:0] bdAddr [4] = '{32'h102, 32'h101, 32'h000, 32'h000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendReq(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_opcode = op;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic releaseResp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({req_ready, mem_req, mem_we, mem_be, resp_valid, resp_err} !== 9'b1_0_0_0000_0_0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want %b",
               {req_ready, mem_req, mem_we, mem_be, resp_valid, resp_err}, 9'b100000000);
    end
    checks++;
    if ({mem_addr, mem_wdata, resp_data, resp_opcode, resp_funct3} !== 106'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h want 0",
               {mem_addr, mem_wdata, resp_data, resp_opcode, resp_funct3});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_loads();
    for (int i = 0; i < 6; i++) begin
      sendReq(OPCODE_LOAD, ldF3[i], ldAddr[i], 32'h0);
      checks++;
      if ({mem_req, mem_we, mem_be, req_ready, mem_addr} !==
          {1'b1, 1'b0, 4'b0000, 1'b0, ldAddr[i] & 32'hFFFFFFFC}) begin
        errors++;
        $display("[TB] FAIL load_bus[%0d] got req=%b we=%b be=%b rdy=%b addr=%h want 1 0 0000 0 %h",
                 i, mem_req, mem_we, mem_be, req_ready, mem_addr, ldAddr[i] & 32'hFFFFFFFC);
      end
      mem_ack   = 1'b1;
      mem_rdata = ldRd[i];
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checks++;
      if ({resp_valid, resp_err, mem_req, resp_data} !== {1'b1, 1'b0, 1'b0, ldExp[i]}) begin
        errors++;
        $display("[TB] FAIL load_resp[%0d] got valid=%b err=%b req=%b data=%h want 1 0 0 %h",
                 i, resp_valid, resp_err, mem_req, resp_data, ldExp[i]);
      end
      checks++;
      if ({resp_opcode, resp_funct3} !== {OPCODE_LOAD, ldF3[i]}) begin
        errors++;
        $display("[TB] FAIL load_fields[%0d] got op=%b f3=%b want %b %b",
                 i, resp_opcode, resp_funct3, OPCODE_LOAD, ldF3[i]);
      end
      releaseResp();
    end
  endtask

  task automatic test_stores();
    for (int i = 0; i < 4; i++) begin
      sendReq(OPCODE_STORE, stF3[i], stAddr[i], stWd[i]);
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, stBe[i], stAddr[i] & 32'hFFFFFFFC, stExp[i]}) begin
        errors++;
        $display("[TB] FAIL store_bus[%0d] got req=%b we=%b be=%b addr=%h wdata=%h want 1 1 %b %h %h",
                 i, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                 stBe[i], stAddr[i] & 32'hFFFFFFFC, stExp[i]);
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      step();
      mem_ack   = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL store_resp[%0d] got valid=%b err=%b data=%h want 1 0 0",
                 i, resp_valid, resp_err, resp_data);
      end
      releaseResp();
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) begin
      sendReq(bdOp[i], bdF3[i], bdAddr[i], 32'h12345678);
      checks++;
      if ({resp_valid, resp_err, mem_req, resp_data} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL error_resp[%0d] got valid=%b err=%b req=%b data=%h want 1 1 0 0",
                 i, resp_valid, resp_err, mem_req, resp_data);
      end
      releaseResp();
    end
  endtask

  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    sendReq(OPCODE_LOAD, FUNCT3_LW, 32'h500, 32'h0);
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      if (mem_req) reqCycles++;
      step();
    end
    checks++;
    if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL timeout_resp got valid=%b err=%b data=%h want 1 1 0",
               resp_valid, resp_err, resp_data);
    end
    checks++;
    if (reqCycles !== 4) begin
      errors++;
      $display("[TB] FAIL timeout_req_cycles got %0d want 4", reqCycles);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    step();
    mem_ack   = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL late_ack_resp got valid=%b err=%b data=%h want 1 1 0",
               resp_valid, resp_err, resp_data);
    end
    releaseResp();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({req_ready, mem_req, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL idle_ack got rdy/req/valid=%b want 100", {req_ready, mem_req, resp_valid});
    end
  endtask

  task automatic test_ack_on_last_cycle();
    sendReq(OPCODE_LOAD, FUNCT3_LW, 32'h700, 32'h0);
    repeat (3) step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL last_cycle_req got %b want 1", mem_req);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h13572468;
    step();
    mem_ack   = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b0, 32'h13572468}) begin
      errors++;
      $display("[TB] FAIL last_cycle_ack got valid=%b err=%b data=%h want 1 0 13572468",
               resp_valid, resp_err, resp_data);
    end
    releaseResp();
  endtask

  task automatic test_backpressure();
    sendReq(OPCODE_LOAD, FUNCT3_LBU, 32'h000, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h000000F0;
    step();
    mem_ack   = 1'b0;
    req_valid  = 1'b1;
    req_opcode = OPCODE_STORE;
    req_funct3 = FUNCT3_SW;
    req_addr   = 32'h900;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, req_ready, resp_err, resp_data, resp_opcode, resp_funct3} !==
          {1'b1, 1'b0, 1'b0, 32'hF0000000, OPCODE_LOAD, FUNCT3_LBU}) begin
        errors++;
        $display("[TB] FAIL hold[%0d] got valid=%b rdy=%b err=%b data=%h op=%b f3=%b want 1 0 0 f0000000",
                 i, resp_valid, req_ready, resp_err, resp_data, resp_opcode, resp_funct3);
      end
      step();
    end
    req_valid = 1'b0;
    releaseResp();
    checks++;
    if ({req_ready, resp_valid, mem_req} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL hold_release got rdy/valid/req=%b want 100", {req_ready, resp_valid, mem_req});
    end
  endtask

  task automatic test_reset_mid_access();
    sendReq(OPCODE_STORE, FUNCT3_SW, 32'h600, 32'hCAFEF00D);
    checks++;
    if ({mem_req, mem_we} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL pre_reset_bus got req/we=%b want 11", {mem_req, mem_we});
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({req_ready, mem_req, mem_we, mem_be, resp_valid, resp_err,
         mem_addr, mem_wdata, resp_data, resp_opcode, resp_funct3} !== {1'b1, 114'h0}) begin
      errors++;
      $display("[TB] FAIL mid_reset got rdy=%b req=%b we=%b be=%b addr=%h wdata=%h data=%h want 1 then zeros",
               req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    resp_ready = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_ack_on_last_cycle();
    test_backpressure();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
